semaforo_scheduler: RTL and testbench
=====================================

Name: semaforo_scheduler

Overview:
- Timed phase scheduler for a two-street intersection (street A, street B) with a shared pedestrian crossing.
- Sequences green → yellow → all-red → next green.
- Enforces minimum and maximum green times from traffic sensors TA/TB.
- Inserts an all-red walk phase on pedestrian request.
- Supersedes the untimed traffic-light FSM as the top-level light controller.

Parameters:
- CNT_W, 8: phase timer width in bits. Every T_* must satisfy 1 ≤ T_* < 2^CNT_W.
- T_GREEN_MIN, 4: minimum green length, in cycles.
- T_GREEN_MAX, 12: maximum green length, in cycles, when the other side has demand.
- T_YELLOW, 2: yellow length, in cycles.
- T_ALLRED, 1: all-red clearance length, in cycles.
- T_WALK, 3: pedestrian walk length, in cycles.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- TA  in  1  traffic present on street A.
- TB  in  1  traffic present on street B.
- ped_req  in  1  pedestrian button; a level or a 1-cycle pulse.
- LA  out  2  street A light.
- LB  out  2  street B light.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  1-cycle pulse when a pedestrian request is served.
- phase  out  3  current state encoding, for debug.

Behaviour:
- Light encoding: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED, 2'b11 OFF.
- Clock and reset: single clock domain. reset = 0 asynchronously forces the reset state; release is sampled on the clock.
- Reset state: S_AG, timer = 0, next_b = 1, ped_pend = 0. Outputs LA = 00, LB = 10, walk = 0, ped_ack = 0, phase = 0.
- States (phase value): S_AG = 0, S_AY = 1, S_AR = 2, S_BG = 3, S_BY = 4, S_BR = 5, S_WALK = 6, S_FLASH = 7 (optional feature only).
- Outputs are Moore, decoded from the state register:
  - AG: LA = 00, LB = 10.
  - AY: LA = 01, LB = 10.
  - BG: LA = 10, LB = 00.
  - BY: LA = 10, LB = 01.
  - AR, BR, WALK: both lights 10.
  - walk = 1 only in S_WALK.
- Timer: cleared to 0 on every state change, +1 per cycle otherwise, saturates at 2^CNT_W−1. t = 0 in the first cycle of a state. A "T-cycle" state exits when t = T−1.
- ped_pend:
  - Set on any cycle with ped_req = 1, except while in S_WALK (requests during WALK are ignored).
  - Cleared on entry to S_WALK.
- S_AG: demand_b = TB | ped_pend. Exit to S_AY when demand_b and t ≥ T_GREEN_MIN−1 and (TA = 0 or t ≥ T_GREEN_MAX−1). Otherwise stay; without demand there is no time limit.
- S_BG: mirror of S_AG with demand_a = TA | ped_pend and hold input TB. Exits to S_BY.
- S_AY: T_YELLOW cycles → S_AR; sets next_b = 1.
- S_BY: T_YELLOW cycles → S_BR; sets next_b = 0.
- S_AR and S_BR: T_ALLRED cycles, then:
  - if ped_pend = 1 → S_WALK;
  - else if next_b = 1 → S_BG;
  - else → S_AG.
- S_WALK:
  - ped_ack = 1 in its first cycle only.
  - Lasts T_WALK cycles, then → S_BG if next_b = 1, else S_AG.
  - At most one walk per all-red crossing.
- Simultaneous events:
  - ped_req in the cycle S_AR exits is not yet visible; it is served at the next all-red.
  - TA = TB = 1 alternates greens at T_GREEN_MAX. Period = 2·(T_GREEN_MAX + T_YELLOW + T_ALLRED) = 30 cycles at defaults.
- Reset mid-operation: reset applies immediately in any state, including yellow and walk. A pending request is discarded.

Optional Feature:
- Macro: SEMAFORO_NIGHT_FLASH_EN.
- When defined:
  - Adds input port `night`, 1 bit, after ped_req.
  - In S_AG or S_BG with night = 1, the green exits at once, ignoring the T_GREEN_MIN rule and demand. The sequence runs through yellow and all-red as normal.
  - The all-red then goes to S_FLASH instead of any green or walk.
  - S_FLASH: LA = LB = 01 for 1 cycle, then 11 for 1 cycle, alternating, starting with 01. walk = 0.
  - ped_req still sets ped_pend, but no walk is served during S_FLASH.
  - night = 0 in S_FLASH → S_AR with next_b = 0, so the next green is AG (or WALK first if ped_pend = 1).
- When undefined: no `night` port and no S_FLASH; phase value 7 is never produced.

Test Plan:
- Quiet A traffic: release reset with TA = 1, TB = 0, ped_req = 0 for 40 cycles → LA = 00, LB = 10, phase = 0 throughout.
- B demand: TA = 0, TB = 1 from reset release (cycle 0) → AG cycles 0–3, AY 4–5, AR 6, LB = 00 from cycle 7 and held.
- Both streets busy: TA = TB = 1 → AG 12 cycles, AY 2, AR 1, BG 12, BY 2, BR 1; pattern repeats with period 30, no walk.
- Pedestrian request: TA = TB = 0, ped_req pulse at cycle 1 → AY 4–5, AR 6, WALK 7–9 with walk = 1 and ped_ack = 1 at cycle 7 only, BG at cycle 10. A second pulse at cycle 8 produces no extra walk.
- Reset mid-phase: assert reset = 0 in the second AY cycle with ped_pend = 1 → LA = 00, LB = 10, ped_ack = 0 before the next clock edge. After release with TA = 1, TB = 0, no walk occurs.
- SEMAFORO_NIGHT_FLASH_EN only: night = 1 at cycle 0, TA = 1 → AY 1–2, AR 3, FLASH from cycle 4 with LA = LB alternating 01/11. night = 0 → AR 1 cycle, then AG.

Source files
------------

// File: rtl/semaforo_scheduler.sv
// Timed phase scheduler for a two-street intersection with a shared pedestrian crossing.
// Optional night flashing mode is enabled by defining SEMAFORO_NIGHT_FLASH_EN.
module semaforo_scheduler #(
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 4,
    parameter int T_GREEN_MAX = 12,
    parameter int T_YELLOW    = 2,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       TA,
    input  logic       TB,
    input  logic       ped_req,
`ifdef SEMAFORO_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;
`ifdef SEMAFORO_NIGHT_FLASH_EN
    localparam logic [1:0] L_OFF    = 2'b11;
`endif

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] TMR_MAX   = '1;

    typedef enum logic [2:0] {
        S_AG    = 3'd0,
        S_AY    = 3'd1,
        S_AR    = 3'd2,
        S_BG    = 3'd3,
        S_BY    = 3'd4,
        S_BR    = 3'd5,
        S_WALK  = 3'd6,
        S_FLASH = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             next_b_q, next_b_d;
    logic             ped_pend_q, ped_pend_d;
    logic             demand_a, demand_b;
`ifdef SEMAFORO_NIGHT_FLASH_EN
    logic             flash_q, flash_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_AG;
            timer_q    <= '0;
            next_b_q   <= 1'b1;
            ped_pend_q <= 1'b0;
`ifdef SEMAFORO_NIGHT_FLASH_EN
            flash_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            next_b_q   <= next_b_d;
            ped_pend_q <= ped_pend_d;
`ifdef SEMAFORO_NIGHT_FLASH_EN
            flash_q    <= flash_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        next_b_d   = next_b_q;
        ped_pend_d = ped_pend_q;
        demand_a   = TA | ped_pend_q;
        demand_b   = TB | ped_pend_q;

        case (state_q)
            S_AG: begin
                if (demand_b && timer_q >= GMIN_LAST && (!TA || timer_q >= GMAX_LAST))
                    state_d = S_AY;
`ifdef SEMAFORO_NIGHT_FLASH_EN
                if (night)
                    state_d = S_AY;
`endif
            end
            S_BG: begin
                if (demand_a && timer_q >= GMIN_LAST && (!TB || timer_q >= GMAX_LAST))
                    state_d = S_BY;
`ifdef SEMAFORO_NIGHT_FLASH_EN
                if (night)
                    state_d = S_BY;
`endif
            end
            S_AY: begin
                if (timer_q == YEL_LAST) begin
                    state_d  = S_AR;
                    next_b_d = 1'b1;
                end
            end
            S_BY: begin
                if (timer_q == YEL_LAST) begin
                    state_d  = S_BR;
                    next_b_d = 1'b0;
                end
            end
            S_AR, S_BR: begin
                if (timer_q == RED_LAST) begin
                    if (ped_pend_q)
                        state_d = S_WALK;
                    else if (next_b_q)
                        state_d = S_BG;
                    else
                        state_d = S_AG;
`ifdef SEMAFORO_NIGHT_FLASH_EN
                    if (night)
                        state_d = S_FLASH;
`endif
                end
            end
            S_WALK: begin
                if (timer_q == WALK_LAST)
                    state_d = next_b_q ? S_BG : S_AG;
            end
`ifdef SEMAFORO_NIGHT_FLASH_EN
            S_FLASH: begin
                if (!night) begin
                    state_d  = S_AR;
                    next_b_d = 1'b0;
                end
            end
`endif
            default: state_d = S_AG;
        endcase

        // A request arriving as the walk starts is considered served by that walk.
        if (ped_req && state_q != S_WALK)
            ped_pend_d = 1'b1;
        if (state_d == S_WALK && state_q != S_WALK)
            ped_pend_d = 1'b0;

        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q == TMR_MAX)
            timer_d = timer_q;
        else
            timer_d = timer_q + 1'b1;

`ifdef SEMAFORO_NIGHT_FLASH_EN
        flash_d = (state_q == S_FLASH && state_d == S_FLASH) ? ~flash_q : 1'b0;
`endif
    end

    always_comb begin
        LA      = L_RED;
        LB      = L_RED;
        walk    = 1'b0;
        ped_ack = 1'b0;
        phase   = state_q;
        case (state_q)
            S_AG: LA = L_GREEN;
            S_AY: LA = L_YELLOW;
            S_BG: LB = L_GREEN;
            S_BY: LB = L_YELLOW;
            S_WALK: begin
                walk    = 1'b1;
                ped_ack = (timer_q == '0);
            end
`ifdef SEMAFORO_NIGHT_FLASH_EN
            S_FLASH: begin
                LA = flash_q ? L_OFF : L_YELLOW;
                LB = flash_q ? L_OFF : L_YELLOW;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_semaforo_scheduler.sv
// Directed self-checking bench for semaforo_scheduler.
module tb_semaforo_scheduler;

    logic       clock;
    logic       reset;
    logic       TA;
    logic       TB;
    logic       ped_req;
`ifdef SEMAFORO_NIGHT_FLASH_EN
    logic       night;
`endif
    logic [1:0] LA;
    logic [1:0] LB;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    int tests;
    int fails;

    semaforo_scheduler dut (
        .clock   (clock),
        .reset   (reset),
        .TA      (TA),
        .TB      (TB),
        .ped_req (ped_req),
`ifdef SEMAFORO_NIGHT_FLASH_EN
        .night   (night),
`endif
        .LA      (LA),
        .LB      (LB),
        .walk    (walk),
        .ped_ack (ped_ack),
        .phase   (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [1:0] la_of(input logic [2:0] ph);
        case (ph)
            3'd0: return 2'b00;
            3'd1: return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] lb_of(input logic [2:0] ph);
        case (ph)
            3'd3: return 2'b00;
            3'd4: return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Hold reset across one edge, then release between edges; returns at the cycle-0 sample point.
    task automatic start(input logic ta, input logic tb);
        reset   = 1'b0;
        ped_req = 1'b0;
        TA      = ta;
        TB      = tb;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        TA = 1'b1; TB = 1'b1; ped_req = 1'b1;
        @(posedge clock);
        #3;
        tests++;
        if (phase !== 3'd0) begin fails++; $display("FAIL reset_phase got %0d exp 0", phase); end
        tests++;
        if (LA !== 2'b00 || LB !== 2'b10) begin
            fails++; $display("FAIL reset_lights got LA=%b LB=%b exp LA=00 LB=10", LA, LB);
        end
        tests++;
        if (walk !== 1'b0 || ped_ack !== 1'b0) begin
            fails++; $display("FAIL reset_walk got walk=%b ack=%b exp 0 0", walk, ped_ack);
        end
        ped_req = 1'b0;
    endtask

    task automatic test_quiet_a;
        start(1'b1, 1'b0);
        for (int c = 0; c < 40; c++) begin
            tests++;
            if (phase !== 3'd0 || LA !== 2'b00 || LB !== 2'b10) begin
                fails++;
                $display("FAIL quiet_a c=%0d got ph=%0d LA=%b LB=%b exp ph=0 LA=00 LB=10", c, phase, LA, LB);
            end
            next_cycle();
        end
    endtask

    task automatic test_b_demand;
        logic [2:0] e;
        start(1'b0, 1'b1);
        for (int c = 0; c < 16; c++) begin
            e = (c < 4) ? 3'd0 : (c < 6) ? 3'd1 : (c == 6) ? 3'd2 : 3'd3;
            tests++;
            if (phase !== e || LA !== la_of(e) || LB !== lb_of(e)) begin
                fails++;
                $display("FAIL b_demand c=%0d got ph=%0d LA=%b LB=%b exp ph=%0d LA=%b LB=%b",
                         c, phase, LA, LB, e, la_of(e), lb_of(e));
            end
            next_cycle();
        end
    endtask

    task automatic test_both_busy;
        logic [2:0] e;
        int m;
        start(1'b1, 1'b1);
        for (int c = 0; c < 65; c++) begin
            m = c % 30;
            e = (m < 12) ? 3'd0 : (m < 14) ? 3'd1 : (m == 14) ? 3'd2 :
                (m < 27) ? 3'd3 : (m < 29) ? 3'd4 : 3'd5;
            tests++;
            if (phase !== e || LA !== la_of(e) || LB !== lb_of(e) || walk !== 1'b0) begin
                fails++;
                $display("FAIL both_busy c=%0d got ph=%0d LA=%b LB=%b walk=%b exp ph=%0d LA=%b LB=%b walk=0",
                         c, phase, LA, LB, walk, e, la_of(e), lb_of(e));
            end
            next_cycle();
        end
    endtask

    task automatic test_ped;
        logic [2:0] e;
        logic       ew, ea;
        start(1'b0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            e  = (c < 4) ? 3'd0 : (c < 6) ? 3'd1 : (c == 6) ? 3'd2 : (c < 10) ? 3'd6 : 3'd3;
            ew = (c >= 7 && c <= 9);
            ea = (c == 7);
            tests++;
            if (phase !== e || LA !== la_of(e) || LB !== lb_of(e) || walk !== ew || ped_ack !== ea) begin
                fails++;
                $display("FAIL ped c=%0d got ph=%0d LA=%b LB=%b walk=%b ack=%b exp ph=%0d LA=%b LB=%b walk=%b ack=%b",
                         c, phase, LA, LB, walk, ped_ack, e, la_of(e), lb_of(e), ew, ea);
            end
            ped_req = (c == 1 || c == 8);
            next_cycle();
        end
        ped_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        start(1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            ped_req = (c == 1);
            next_cycle();
        end
        ped_req = 1'b0;
        tests++;
        if (phase !== 3'd1) begin fails++; $display("FAIL reset_mid_pre got ph=%0d exp 1", phase); end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (LA !== 2'b00 || LB !== 2'b10 || ped_ack !== 1'b0 || phase !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_async got LA=%b LB=%b ack=%b ph=%0d exp LA=00 LB=10 ack=0 ph=0",
                     LA, LB, ped_ack, phase);
        end
        TA = 1'b1;
        TB = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            tests++;
            if (phase !== 3'd0 || walk !== 1'b0 || ped_ack !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_after c=%0d got ph=%0d walk=%b ack=%b exp ph=0 walk=0 ack=0",
                         c, phase, walk, ped_ack);
            end
            next_cycle();
        end
    endtask

`ifdef SEMAFORO_NIGHT_FLASH_EN
    task automatic test_night;
        logic [2:0] e;
        logic [1:0] el;
        night = 1'b1;
        start(1'b1, 1'b0);
        for (int c = 0; c < 13; c++) begin
            if (c == 0)       e = 3'd0;
            else if (c < 3)   e = 3'd1;
            else if (c == 3)  e = 3'd2;
            else if (c <= 10) e = 3'd7;
            else if (c == 11) e = 3'd2;
            else              e = 3'd0;
            el = (e == 3'd7) ? ((((c - 4) % 2) == 0) ? 2'b01 : 2'b11) : 2'b00;
            tests++;
            if (phase !== e) begin
                fails++; $display("FAIL night_phase c=%0d got %0d exp %0d", c, phase, e);
            end
            if (e == 3'd7) begin
                tests++;
                if (LA !== el || LB !== el || walk !== 1'b0) begin
                    fails++;
                    $display("FAIL night_flash c=%0d got LA=%b LB=%b walk=%b exp LA=%b LB=%b walk=0",
                             c, LA, LB, walk, el, el);
                end
            end
            if (c == 10) night = 1'b0;
            next_cycle();
        end
    endtask
`endif

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b0;
        TA      = 1'b0;
        TB      = 1'b0;
        ped_req = 1'b0;
`ifdef SEMAFORO_NIGHT_FLASH_EN
        night   = 1'b0;
`endif
        test_reset();
        test_quiet_a();
        test_b_demand();
        test_both_busy();
        test_ped();
        test_reset_mid();
`ifdef SEMAFORO_NIGHT_FLASH_EN
        test_night();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
